// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - shared seven-segment encodings, FSM states and BCD helper
package display_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;

  // Double-dabble correction: a digit of 5 or more would overflow past 9 on the next shift
  function automatic logic [3:0] add3(input logic [3:0] d);
    return (d >= 4'd5) ? (d + 4'd3) : d;
  endfunction

endpackage

// File: rtl/count_bcd_display_if.sv
// rtl/count_bcd_display_if.sv - conversion request and display result bundle
interface count_bcd_display_if #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
);
  logic [WIDTH-1:0]    Bin;
  logic                Load;
  logic                Busy;
  logic                Done;
  logic [4*DIGITS-1:0] BCD;
  logic [6:0]          HEX0;
  logic [6:0]          HEX1;
  logic [6:0]          HEX2;
  logic [6:0]          HEX3;
  logic [6:0]          HEX4;

  modport master (
    output Bin, Load,
    input  Busy, Done, BCD, HEX0, HEX1, HEX2, HEX3, HEX4
  );

  modport slave (
    input  Bin, Load,
    output Busy, Done, BCD, HEX0, HEX1, HEX2, HEX3, HEX4
  );
endinterface

// File: rtl/count_bcd_display_seg7_decode.sv
// rtl/count_bcd_display_seg7_decode.sv - one BCD digit to active-low seven-segment pattern
module seg7_decode
  import display_pkg::*;
(
  input  logic [3:0] i_digit,
  input  logic       i_blank,
  output logic [6:0] o_seg
);

  // Standard digit patterns; codes 10-15 and forced blanking light nothing
  always_comb begin
    o_seg = SEG_BLANK;
    if (!i_blank) begin
      case (i_digit)
        4'd0:    o_seg = SEG_0;
        4'd1:    o_seg = SEG_1;
        4'd2:    o_seg = SEG_2;
        4'd3:    o_seg = SEG_3;
        4'd4:    o_seg = SEG_4;
        4'd5:    o_seg = SEG_5;
        4'd6:    o_seg = SEG_6;
        4'd7:    o_seg = SEG_7;
        4'd8:    o_seg = SEG_8;
        4'd9:    o_seg = SEG_9;
        default: o_seg = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/count_bcd_display.sv
// rtl/count_bcd_display.sv - serial binary-to-BCD converter driving five HEX displays
module count_bcd_display
  import display_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int DIGITS   = 5,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic                Clk,
  input  logic                Clr,
  count_bcd_display_if.slave  bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int BCD_W = 4 * DIGITS;

  state_t                   r_state;
  state_t                   w_next_state;
  logic                     w_load;
  logic                     w_shift;
  logic                     w_finish;
  logic [WIDTH-1:0]         r_shreg;
  logic [BCD_W-1:0]         r_work;
  logic [BCD_W-1:0]         w_work_adj;
  logic [BCD_W-1:0]         r_bcd;
  logic [CNT_W-1:0]         r_cnt;
  logic                     r_done;
  logic                     w_zero_run;
  logic [DIGITS-1:0]        w_blank;
  logic [DIGITS-1:0][6:0]   w_seg;
  logic [4:0][6:0]          w_hex;

  // FSM state register
  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // FSM next state and datapath strobes; Load only matters in IDLE
  always_comb begin
    w_next_state = r_state;
    w_load       = 1'b0;
    w_shift      = 1'b0;
    w_finish     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.Load) begin
          w_load       = 1'b1;
          w_next_state = S_SHIFT;
        end
      end
      S_SHIFT: begin
        w_shift = 1'b1;
        if (r_cnt == CNT_W'(1)) begin
          w_next_state = S_DONE;
        end
      end
      S_DONE: begin
        w_finish     = 1'b1;
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Add-3 correction of every work digit ahead of the shift
  always_comb begin
    w_work_adj = '0;
    for (int i = 0; i < DIGITS; i++) begin
      w_work_adj[4*i +: 4] = add3(r_work[4*i +: 4]);
    end
  end

  // Shift engine and result register; the display only moves when a conversion completes
  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr) begin
      r_shreg <= '0;
      r_work  <= '0;
      r_cnt   <= '0;
      r_bcd   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_load) begin
        r_shreg <= bus.Bin;
        r_work  <= '0;
        r_cnt   <= CNT_W'(WIDTH);
      end else if (w_shift) begin
        // The top work bit is always zero after correction because 10**DIGITS > 2**WIDTH
        {r_work, r_shreg} <= {w_work_adj[BCD_W-2:0], r_shreg, 1'b0};
        r_cnt             <= r_cnt - 1'b1;
      end
      if (w_finish) begin
        r_bcd  <= r_work;
        r_done <= 1'b1;
      end
    end
  end

  // Leading-zero blanking: a digit blanks when it and everything above it are zero
  always_comb begin
    w_blank    = '0;
    w_zero_run = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      w_zero_run = w_zero_run & (r_bcd[4*i +: 4] == 4'd0);
      if (BLANK_LZ && (i != 0)) begin
        w_blank[i] = w_zero_run;
      end
    end
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_dec
    seg7_decode u_seg7_decode (
      .i_digit (r_bcd[4*g +: 4]),
      .i_blank (w_blank[g]),
      .o_seg   (w_seg[g])
    );
  end

  // Map decoded digits onto the five physical displays; missing digits stay dark
  for (genvar h = 0; h < 5; h++) begin : g_hex
    if (h < DIGITS) begin : g_used
      assign w_hex[h] = w_seg[h];
    end else begin : g_dark
      assign w_hex[h] = SEG_BLANK;
    end
  end

  assign bus.Busy = (r_state == S_SHIFT);
  assign bus.Done = r_done;
  assign bus.BCD  = r_bcd;
  assign bus.HEX0 = w_hex[0];
  assign bus.HEX1 = w_hex[1];
  assign bus.HEX2 = w_hex[2];
  assign bus.HEX3 = w_hex[3];
  assign bus.HEX4 = w_hex[4];

endmodule

// File: tb/tb_count_bcd_display.sv
// tb/tb_count_bcd_display.sv - directed self-checking bench for count_bcd_display
module tb_count_bcd_display;

  localparam logic [6:0] SB = 7'h7F;
  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000;
  localparam logic [6:0] S4 = 7'b0011001;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] S6 = 7'b0000010;

  logic clk;
  logic clr_n;
  int   n_checks;
  int   n_errors;
  int   busy_cnt;
  int   done_cnt;
  int   done_at;

  count_bcd_display_if #(.WIDTH(16), .DIGITS(5)) bus_if ();

  count_bcd_display #(.WIDTH(16), .DIGITS(5), .BLANK_LZ(1'b1)) dut (
    .Clk (clk),
    .Clr (clr_n),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_hex(input string tag, input logic [6:0] h4, input logic [6:0] h3,
                           input logic [6:0] h2, input logic [6:0] h1, input logic [6:0] h0);
    check({tag, " hex4"}, {25'd0, bus_if.HEX4}, {25'd0, h4});
    check({tag, " hex3"}, {25'd0, bus_if.HEX3}, {25'd0, h3});
    check({tag, " hex2"}, {25'd0, bus_if.HEX2}, {25'd0, h2});
    check({tag, " hex1"}, {25'd0, bus_if.HEX1}, {25'd0, h1});
    check({tag, " hex0"}, {25'd0, bus_if.HEX0}, {25'd0, h0});
  endtask

  // One Load pulse, then watch 24 cycles; j counts negedges after the Load edge.
  // Optional late Load at cycle late_j and reset pulse at cycle abort_j (-1 disables).
  task automatic run_conv(input string tag, input logic [15:0] bin, input logic [19:0] prev_bcd,
                          input int late_j, input logic [15:0] late_bin, input int abort_j);
    busy_cnt = 0;
    done_cnt = 0;
    done_at  = -1;
    @(negedge clk);
    bus_if.Bin  = bin;
    bus_if.Load = 1'b1;
    @(posedge clk);
    for (int j = 0; j < 24; j++) begin
      @(negedge clk);
      if (bus_if.Busy) busy_cnt++;
      if (bus_if.Done) begin
        done_cnt++;
        done_at = j;
      end
      if (j == 5) check({tag, " bcd held"}, {12'd0, bus_if.BCD}, {12'd0, prev_bcd});
      if (j == 0) bus_if.Load = 1'b0;
      if (j == late_j) begin
        bus_if.Load = 1'b1;
        bus_if.Bin  = late_bin;
      end else if (j == late_j + 1) begin
        bus_if.Load = 1'b0;
      end
      if (j == abort_j) begin
        clr_n = 1'b0;
        #1;
        check({tag, " abort busy"}, {31'd0, bus_if.Busy}, 32'd0);
        check({tag, " abort bcd"},  {12'd0, bus_if.BCD},  32'd0);
        check({tag, " abort done"}, {31'd0, bus_if.Done}, 32'd0);
      end else if (j == abort_j + 1) begin
        clr_n = 1'b1;
      end
    end
  endtask

  initial begin
    n_checks    = 0;
    n_errors    = 0;
    clr_n       = 1'b0;
    bus_if.Bin  = '0;
    bus_if.Load = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst busy", {31'd0, bus_if.Busy}, 32'd0);
    check("rst done", {31'd0, bus_if.Done}, 32'd0);
    check("rst bcd",  {12'd0, bus_if.BCD},  32'd0);
    check_hex("rst", SB, SB, SB, SB, S0);
    clr_n = 1'b1;

    // 1234: latency and Busy window
    run_conv("1234", 16'd1234, 20'h00000, -1, 16'd0, -1);
    check("1234 busy cycles", busy_cnt, 16);
    check("1234 done count",  done_cnt, 1);
    check("1234 done cycle",  done_at,  17);
    check("1234 bcd", {12'd0, bus_if.BCD}, 32'h01234);
    check_hex("1234", SB, S1, S2, S3, S4);

    // Full-scale input lights every digit
    run_conv("65535", 16'hFFFF, 20'h01234, -1, 16'd0, -1);
    check("65535 done count", done_cnt, 1);
    check("65535 bcd", {12'd0, bus_if.BCD}, 32'h65535);
    check_hex("65535", S6, S5, S5, S3, S5);

    // Load during SHIFT is ignored
    run_conv("500", 16'd500, 20'h65535, 3, 16'd9, -1);
    check("500 done count", done_cnt, 1);
    check("500 busy cycles", busy_cnt, 16);
    check("500 bcd", {12'd0, bus_if.BCD}, 32'h00500);
    check_hex("500", SB, SB, S5, S0, S0);

    // Reset in the 8th SHIFT cycle aborts with no Done
    run_conv("abort", 16'd777, 20'h00500, -1, 16'd0, 7);
    check("abort done count", done_cnt, 0);
    check("abort busy cycles", busy_cnt, 8);
    check("abort bcd after", {12'd0, bus_if.BCD}, 32'd0);

    run_conv("42", 16'd42, 20'h00000, -1, 16'd0, -1);
    check("42 done count", done_cnt, 1);
    check("42 bcd", {12'd0, bus_if.BCD}, 32'h00042);
    check_hex("42", SB, SB, SB, S4, S2);

    // Internal zeros stay lit
    run_conv("1000", 16'd1000, 20'h00042, -1, 16'd0, -1);
    check("1000 bcd", {12'd0, bus_if.BCD}, 32'h01000);
    check_hex("1000", SB, S1, S0, S0, S0);

    // Zero result: only the units digit shows
    run_conv("zero", 16'd0, 20'h01000, -1, 16'd0, -1);
    check("zero done cycle", done_at, 17);
    check("zero bcd", {12'd0, bus_if.BCD}, 32'd0);
    check_hex("zero", SB, SB, SB, SB, S0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
